// File: rtl/coin_encoder.sv
// Coin sensor line encoder: queues coin requests in a 4-entry FIFO and emits
// each one as a 4-cycle serial frame (start 0, code[1], code[0], stop 1).
module coin_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       penny,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    output logic       req_ready,
    output logic       out,
    output logic       busy,
    output logic       err,
    output logic [7:0] frames_sent
);

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned FRAME_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT1,
        S_BIT0,
        S_STOP
    } state_t;

    state_t                         state_q, state_d;
    logic [CODE_W-1:0]              code_q, code_d;
    logic [DEPTH-1:0][CODE_W-1:0]   fifo_q, fifo_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           out_q, out_d;
    logic                           busy_q, busy_d;
    logic                           err_q, err_d;
    logic                           ready_q, ready_d;
    logic [FRAME_W-1:0]             frames_q, frames_d;

    logic [3:0]        coin_bits;
    logic              one_hot;
    logic [CODE_W-1:0] req_code;
    logic              accept;
    logic              push;
    logic              pop;

    // Request decode and acceptance
    always_comb begin
        coin_bits = {quarter, dime, nickel, penny};
        one_hot   = $onehot(coin_bits);
        req_code  = 2'b00;
        if (quarter)     req_code = 2'b11;
        else if (dime)   req_code = 2'b10;
        else if (nickel) req_code = 2'b01;
        accept = req_valid && ready_q;
        push   = accept && one_hot;
    end

    // Frame FSM, FIFO bookkeeping and registered output values
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_BIT1;
            S_BIT1:  state_d = S_BIT0;
            S_BIT0:  state_d = S_STOP;
            S_STOP: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            code_d   = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = req_code;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        frames_d = frames_q + FRAME_W'((state_q == S_BIT0) && (state_d == S_STOP));

        // Line value is a pure decode of the next state, so out mirrors the state register
        unique case (state_d)
            S_START: out_d = 1'b0;
            S_BIT1:  out_d = code_d[1];
            S_BIT0:  out_d = code_d[0];
            default: out_d = 1'b1;
        endcase

        busy_d  = (state_d != S_IDLE) || (count_d != '0);
        ready_d = (count_d != CNT_W'(DEPTH));
        err_d   = accept && !one_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            frames_q <= frames_d;
        end
    end

    assign req_ready   = ready_q;
    assign out         = out_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_coin_encoder.sv
// Self-checking bench for coin_encoder: queue-based line model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_coin_encoder;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [3:0] coins;
    logic       req_ready;
    logic       out;
    logic       busy;
    logic       err;
    logic [7:0] frames_sent;

    coin_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .penny       (coins[0]),
        .nickel      (coins[1]),
        .dime        (coins[2]),
        .quarter     (coins[3]),
        .req_ready   (req_ready),
        .out         (out),
        .busy        (busy),
        .err         (err),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending codes, and the bits still to appear on the line (front = current bit)
    logic [1:0] q_fifo[$];
    bit         line[$];
    logic       m_out, m_busy, m_err, m_ready;
    logic [7:0] m_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] code_of(input logic [3:0] c);
        if (c[3]) return 2'd3;
        if (c[2]) return 2'd2;
        if (c[1]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_step();
        int         pre_size;
        bit         acc;
        bit         moved;
        logic [1:0] c;
        if (reset) begin
            q_fifo.delete();
            line.delete();
            m_frames = 8'd0;
            m_err    = 1'b0;
        end else begin
            pre_size = q_fifo.size();
            acc      = req_valid && (pre_size < 4);
            moved    = 1'b0;
            if (line.size() != 0) begin
                void'(line.pop_front());
                moved = 1'b1;
            end
            if (moved && line.size() == 1) m_frames = m_frames + 8'd1;
            if (line.size() == 0 && pre_size != 0) begin
                c = q_fifo.pop_front();
                line.push_back(1'b0);
                line.push_back(c[1]);
                line.push_back(c[0]);
                line.push_back(1'b1);
            end
            m_err = acc && ($countones(coins) != 1);
            if (acc && $countones(coins) == 1) q_fifo.push_back(code_of(coins));
        end
        m_out   = (line.size() != 0) ? line[0] : 1'b1;
        m_busy  = (line.size() != 0) || (q_fifo.size() != 0);
        m_ready = (q_fifo.size() < 4);
    endtask

    // One clock: advance model at the edge, compare everything at the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("out", 32'(out), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("err", 32'(err), 32'(m_err));
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("frames_sent", 32'(frames_sent), 32'(m_frames));
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b1; coins = 4'b0100;
        cyc();
        reset = 1'b0; req_valid = 1'b0; coins = 4'b0000;
    endtask

    logic [15:0] bits;
    logic [3:0]  seq[6];
    int          k;
    int          guard;
    int          accepted;

    initial begin
        reset = 1'b1; req_valid = 1'b0; coins = 4'b0000;
        m_out = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_ready = 1'b1; m_frames = 8'd0;
        cyc();
        do_reset();
        chk("rst_out", 32'(out), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);

        // Single dime frame
        req_valid = 1'b1; coins = 4'b0100;
        cyc(); chk("dime_n0", 32'(out), 32'd1);
        req_valid = 1'b0; coins = 4'b0000;
        cyc(); chk("dime_n1", 32'(out), 32'd0);
        cyc(); chk("dime_n2", 32'(out), 32'd1);
        cyc(); chk("dime_n3", 32'(out), 32'd0);
        cyc(); chk("dime_n4", 32'(out), 32'd1);
        chk("dime_frames", 32'(frames_sent), 32'd1);
        chk("dime_busy_n4", 32'(busy), 32'd1);
        cyc(); chk("dime_busy_n5", 32'(busy), 32'd0);

        // Four coins on consecutive cycles: contiguous 16-bit pattern
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        req_valid = 1'b1; coins = seq[0];
        cyc();
        bits = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 3) begin req_valid = 1'b1; coins = seq[i+1]; end
            else begin req_valid = 1'b0; coins = 4'b0000; end
            cyc();
            bits = {bits[14:0], out};
        end
        chk("four_pattern", 32'(bits), 32'h1357);
        chk("four_frames", 32'(frames_sent), 32'd5);
        cyc();

        // Non-one-hot requests are rejected with a one-cycle err pulse
        req_valid = 1'b1; coins = 4'b0101;
        cyc(); chk("bad_two_err", 32'(err), 32'd1);
        coins = 4'b0000;
        cyc(); chk("bad_zero_err", 32'(err), 32'd1);
        req_valid = 1'b0;
        cyc(); chk("bad_err_clear", 32'(err), 32'd0);
        chk("bad_out", 32'(out), 32'd1);
        chk("bad_frames", 32'(frames_sent), 32'd5);
        chk("bad_busy", 32'(busy), 32'd0);

        // Back-to-back requests fill the FIFO; held request waits for a pop
        do_reset();
        seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0100;
        seq[3] = 4'b0010; seq[4] = 4'b1000; seq[5] = 4'b0001;
        k = 0; guard = 0;
        while (k < 6 && guard < 50) begin
            req_valid = 1'b1; coins = seq[k];
            if (m_ready) k++;
            cyc();
            guard++;
            if (guard == 5) chk("full_ready_low", 32'(req_ready), 32'd0);
        end
        chk("full_all_accepted", 32'(k), 32'd6);
        req_valid = 1'b0; coins = 4'b0000;
        for (int i = 0; i < 30; i++) cyc();
        chk("full_frames", 32'(frames_sent), 32'd6);

        // Reset during BIT1 of a quarter frame with two requests queued
        do_reset();
        req_valid = 1'b1; coins = 4'b1000; cyc();
        coins = 4'b0100; cyc();
        coins = 4'b0010; cyc();
        chk("abort_bit1_out", 32'(out), 32'd1);
        reset = 1'b1; coins = 4'b0001;
        cyc();
        reset = 1'b0; req_valid = 1'b0; coins = 4'b0000;
        chk("abort_out", 32'(out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frames", 32'(frames_sent), 32'd0);
        for (int i = 0; i < 10; i++) cyc();
        chk("abort_no_frames", 32'(frames_sent), 32'd0);

        // Randomized traffic with occasional resets and malformed requests
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) coins = 4'($urandom);
            else coins = 4'(1 << $urandom_range(0, 3));
            cyc();
        end
        reset = 1'b0; req_valid = 1'b0; coins = 4'b0000;

        // 256 penny frames wrap the counter to zero
        do_reset();
        accepted = 0; guard = 0;
        while (accepted < 256 && guard < 3000) begin
            req_valid = 1'b1; coins = 4'b0001;
            if (m_ready) accepted++;
            cyc();
            guard++;
        end
        req_valid = 1'b0; coins = 4'b0000;
        guard = 0;
        while (m_busy && guard < 100) begin
            cyc();
            guard++;
        end
        chk("wrap_drained", 32'(m_busy), 32'd0);
        chk("wrap_frames", 32'(frames_sent), 32'd0);
        chk("wrap_idle_out", 32'(out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_encoder.md
COIN_ENCODER -- requirements
Module: coin_encoder

Interface
REQ-001 The module SHALL have no parameters; frame format and FIFO depth (4) are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  a coin request is presented this cycle.
REQ-005 penny, nickel, dime, quarter  input  1 each  coin select; exactly one SHALL be high for a valid request.
REQ-006 req_ready  output  1  FIFO can accept a request (high when FIFO not full).
REQ-007 out  output  1  registered serial line to the coin sensor; idles high.
REQ-008 busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 err  output  1  one-cycle pulse flagging a rejected, non-one-hot request.
REQ-010 frames_sent  output  8  count of completed frames; wraps 255->0.

Function
REQ-011 Coin code SHALL be 2'b00 penny, 2'b01 nickel, 2'b10 dime, 2'b11 quarter.
REQ-012 Frame on out SHALL be 4 cycles: start 0, code[1], code[0], stop 1; line held at 1 when idle.
REQ-013 A request SHALL be accepted at an edge where req_valid && req_ready.
REQ-014 An accepted one-hot request SHALL be written to a 4-entry FIFO (code only).
REQ-015 An accepted non-one-hot request (zero or >1 coin bits high) SHALL NOT be written; err SHALL be 1 for the following cycle only.
REQ-016 req_ready SHALL be !full, from registered occupancy only (no combinational dependence on pop).
REQ-017 FSM states: IDLE, START, BIT1, BIT0, STOP; out driven from the state register (1, 0, code[1], code[0], 1).
REQ-018 IDLE -> START with FIFO pop when FIFO non-empty (registered occupancy); else stay IDLE.
REQ-019 START -> BIT1 -> BIT0 -> STOP unconditionally, one cycle each; popped code held in a register for the frame.
REQ-020 STOP -> START with pop if FIFO non-empty, else IDLE; back-to-back frames SHALL therefore repeat every 4 cycles with no extra idle cycle.
REQ-021 Latency: request accepted at edge N into an empty FIFO with FSM in IDLE -> out = 0 (start) after edge N+1, code[1] after N+2, code[0] after N+3, stop after N+4.
REQ-022 frames_sent SHALL increment by 1 on the edge entering STOP; 8-bit wrap 255 -> 0.
REQ-023 Simultaneous push and pop: both SHALL occur; occupancy unchanged; FIFO order preserved.
REQ-024 Push into empty FIFO SHALL NOT be popped in the same edge (pop sees pre-edge occupancy).
REQ-025 When full, req_ready = 0 even if a pop occurs that cycle; no request lost or overwritten.
REQ-026 busy = (state != IDLE) || (occupancy != 0).

Reset
REQ-027 On reset: state IDLE, out = 1, FIFO flushed (occupancy 0), req_ready = 1, busy = 0, err = 0, frames_sent = 0.
REQ-028 Reset mid-frame SHALL abort the frame: out = 1 after that edge, no frames_sent increment, pending requests discarded.
REQ-029 A request presented in a reset cycle SHALL be ignored (not stored, no err).

Verification
REQ-030 Reset, then dime request at edge N -> out = 1,0,1,0,1 after edges N..N+4; frames_sent = 1; busy low from edge N+5.
REQ-031 Four requests penny, nickel, dime, quarter on consecutive cycles -> out = 0 00 1, 0 01 1, 0 10 1, 0 11 1 contiguous (16 cycles), frames_sent = 4.
REQ-032 Five back-to-back requests while FSM busy -> req_ready drops to 0 when occupancy reaches 4; held request accepted only after next pop; all five frames emitted in order.
REQ-033 req_valid with penny=dime=1, then with all coin bits 0 -> err pulses 1 cycle each, out stays 1, frames_sent unchanged.
REQ-034 Reset asserted during BIT1 of a quarter frame with 2 queued -> out = 1 next cycle, busy = 0, frames_sent = 0, no further frames.
REQ-035 256 penny frames -> frames_sent wraps to 0.
